// File: rtl/k005297_pgseq.sv
// Page sequencer: captures a 12-bit page number on request and shifts it out LSB first
// in rotation phases 0..11 of a free-running 20-phase counter. All outputs are registers.
module k005297_pgseq (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic        i_PG_REQ,
  input  logic [11:0] i_PG_DIN,
  output logic        o_PG_ACK,
  output logic        o_PGREG_LD,
  output logic        o_PGREG_SR_LD_EN,
  output logic [19:0] o_ROT20_n,
  output logic        o_SHIFT,
  output logic        o_PG_SDATA,
  output logic        o_PG_DONE,
  output logic        o_BUSY
);

  typedef enum logic [2:0] {IDLE, LATCH, ARM, SHIFT, DONE} state_t;

  state_t      state, state_d;
  logic [11:0] shadow, shadow_d;
  logic [11:0] sreg, sreg_d;
  logic        accept;
  logic        ph11, ph19;

  // The rotation register doubles as the phase counter.
  assign ph11 = ~o_ROT20_n[11];
  assign ph19 = ~o_ROT20_n[19];

  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    sreg_d   = sreg;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        // Registered BUSY still reflects DONE on the first IDLE tick, giving a one-tick gap.
        accept = i_PG_REQ & ~o_BUSY;
        if (accept) begin
          state_d  = LATCH;
          shadow_d = i_PG_DIN;
        end
      end
      LATCH: state_d = ARM;
      ARM: begin
        if (ph19) begin
          state_d = SHIFT;
          sreg_d  = shadow;
        end
      end
      SHIFT: begin
        sreg_d = {1'b0, sreg[11:1]};
        if (ph11) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state            <= IDLE;
      shadow           <= 12'h000;
      sreg             <= 12'h000;
      o_ROT20_n        <= 20'hFFFFE;
      o_PG_ACK         <= 1'b0;
      o_PGREG_LD       <= 1'b0;
      o_PGREG_SR_LD_EN <= 1'b0;
      o_SHIFT          <= 1'b0;
      o_PG_SDATA       <= 1'b0;
      o_PG_DONE        <= 1'b0;
      o_BUSY           <= 1'b0;
    end else if (!i_CLK2M_PCEN_n) begin
      state            <= state_d;
      shadow           <= shadow_d;
      sreg             <= sreg_d;
      o_ROT20_n        <= {o_ROT20_n[18:0], o_ROT20_n[19]};
      o_PG_ACK         <= accept;
      o_PGREG_LD       <= (state == LATCH);
      o_PGREG_SR_LD_EN <= (state == ARM);
      o_SHIFT          <= (state == SHIFT);
      o_PG_SDATA       <= (state == SHIFT) & sreg[0];
      o_PG_DONE        <= (state == DONE);
      o_BUSY           <= (state != IDLE);
    end
  end

endmodule
